regfile_ctrl: RTL and testbench

//  Write-port controller for the 32x32 register bank. It drives the bank's single write port
//  (enc/addrc/datac) and does three jobs:
//  - clears every register after reset by sweeping the bank;
//  - arbitrates round-robin between two writeback requesters (A = ALU, B = load unit);
//  - keeps a pending-write scoreboard so issue logic can stall on RAW hazards.

---
 rtl/regfile_ctrl_pkg.sv | 10 +
 rtl/regfile_ctrl_rr_arbiter2.sv | 25 ++
 rtl/regfile_ctrl.sv | 127 ++++++++++++
 tb/tb_regfile_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and types for the register-bank write-port controller.
package regfile_ctrl_pkg;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int CNT_W    = ADDR_W + 1;
    localparam int BANK_AW  = 32;

    typedef enum logic {INIT, RUN} state_t;
endpackage

// File: rtl/regfile_ctrl_rr_arbiter2.sv
// Two-requester round-robin arbiter: a lone request wins outright, and a tie goes
// to whichever requester was not granted last.
module rr_arbiter2 (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);
    logic prio_b;

    always_comb begin
        gnt_a = en & req_a & (~req_b | ~prio_b);
        gnt_b = en & req_b & (~req_a | prio_b);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)     prio_b <= 1'b0;
        else if (gnt_a) prio_b <= 1'b1;
        else if (gnt_b) prio_b <= 1'b0;
    end
endmodule

// File: rtl/regfile_ctrl.sv
// Write-port controller for the register bank: post-reset clear sweep, A/B writeback
// arbitration and a RAW scoreboard. Define REGFILE_CTRL_BYPASS_EN to add the bypass outputs.
module regfile_ctrl
    import regfile_ctrl_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               a_valid,
    input  logic [ADDR_W-1:0]  a_addr,
    input  logic [DATA_W-1:0]  a_data,
    output logic               a_ready,
    input  logic               b_valid,
    input  logic [ADDR_W-1:0]  b_addr,
    input  logic [DATA_W-1:0]  b_data,
    output logic               b_ready,
    input  logic               issue_valid,
    input  logic [ADDR_W-1:0]  issue_addr,
    input  logic [ADDR_W-1:0]  rd_addra,
    input  logic [ADDR_W-1:0]  rd_addrb,
    output logic               hazard_a,
    output logic               hazard_b,
`ifdef REGFILE_CTRL_BYPASS_EN
    output logic               byp_a_valid,
    output logic [DATA_W-1:0]  byp_a_data,
    output logic               byp_b_valid,
    output logic [DATA_W-1:0]  byp_b_data,
`endif
    output logic               enc,
    output logic [BANK_AW-1:0] addrc,
    output logic [DATA_W-1:0]  datac,
    output logic               init_done
);
    state_t              state, state_nxt;
    logic [CNT_W-1:0]    sweep_cnt;
    logic                sweep_last;
    logic [ADDR_W-1:0]   waddr;
    logic [NUM_REGS-1:0] pending;
    logic                gnt_a, gnt_b;
    logic                win_valid;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;

    // sweep_cnt reaches NUM_REGS while the last register's clear is on the port.
    assign sweep_last = (sweep_cnt == CNT_W'(NUM_REGS));
    assign addrc      = {{(BANK_AW-ADDR_W){1'b0}}, waddr};

    rr_arbiter2 u_arb (
        .clock (clock),
        .reset (reset),
        .en    (state == RUN),
        .req_a (a_valid),
        .req_b (b_valid),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= INIT;
        else        state <= state_nxt;
    end

    // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        state_nxt = state;
        if (state == INIT && sweep_last) state_nxt = RUN;
    end

    always_comb begin
        init_done = (state == RUN);
        a_ready   = gnt_a;
        b_ready   = gnt_b;
        win_valid = gnt_a | gnt_b;
        win_addr  = gnt_a ? a_addr : b_addr;
        win_data  = gnt_a ? a_data : b_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enc       <= 1'b0;
            waddr     <= '0;
            datac     <= '0;
            sweep_cnt <= '0;
        end else if (state == INIT) begin
            enc <= ~sweep_last;
            if (!sweep_last) begin
                waddr     <= sweep_cnt[ADDR_W-1:0];
                datac     <= '0;
                sweep_cnt <= sweep_cnt + 1'b1;
            end
        end else begin
            // Writes to register 0 are accepted but never reach the bank.
            enc <= win_valid & (win_addr != '0);
            if (win_valid) begin
                waddr <= win_addr;
                datac <= win_data;
            end
        end
    end

    // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset like any other state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            if (enc) pending[waddr] <= 1'b0;
            // Later assignment wins, so a same-edge issue keeps the bit set.
            if (state == RUN && issue_valid && issue_addr != '0)
                pending[issue_addr] <= 1'b1;
        end
    end

`ifdef REGFILE_CTRL_BYPASS_EN
    always_comb begin
        byp_a_valid = enc & (waddr == rd_addra) & (rd_addra != '0);
        byp_b_valid = enc & (waddr == rd_addrb) & (rd_addrb != '0);
        byp_a_data  = datac;
        byp_b_data  = datac;
        hazard_a    = ((state == INIT) | (pending[rd_addra] & (rd_addra != '0))) & ~byp_a_valid;
        hazard_b    = ((state == INIT) | (pending[rd_addrb] & (rd_addrb != '0))) & ~byp_b_valid;
    end
`else
    always_comb begin
        hazard_a = (state == INIT) | (pending[rd_addra] & (rd_addra != '0));
        hazard_b = (state == INIT) | (pending[rd_addrb] & (rd_addrb != '0));
    end
`endif
endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl: sweep, arbitration, scoreboard, register 0, mid-sweep reset
// and, when REGFILE_CTRL_BYPASS_EN is defined, the bypass outputs.
module tb_regfile_ctrl;
    logic        clock = 1'b0;
    logic        reset;
    logic        a_valid, b_valid, issue_valid;
    logic [4:0]  a_addr, b_addr, issue_addr, rd_addra, rd_addrb;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, hazard_a, hazard_b, enc, init_done;
    logic [31:0] addrc, datac;
`ifdef REGFILE_CTRL_BYPASS_EN
    logic        byp_a_valid, byp_b_valid;
    logic [31:0] byp_a_data, byp_b_data;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    regfile_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .a_valid     (a_valid),
        .a_addr      (a_addr),
        .a_data      (a_data),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_addr      (b_addr),
        .b_data      (b_data),
        .b_ready     (b_ready),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .rd_addra    (rd_addra),
        .rd_addrb    (rd_addrb),
        .hazard_a    (hazard_a),
        .hazard_b    (hazard_b),
`ifdef REGFILE_CTRL_BYPASS_EN
        .byp_a_valid (byp_a_valid),
        .byp_a_data  (byp_a_data),
        .byp_b_valid (byp_b_valid),
        .byp_b_data  (byp_b_data),
`endif
        .enc         (enc),
        .addrc       (addrc),
        .datac       (datac),
        .init_done   (init_done)
    );

    task automatic test_reset;
        reset = 1'b0;
        a_valid = 0; b_valid = 0; issue_valid = 0;
        a_addr = 0; b_addr = 0; issue_addr = 0; rd_addra = 1; rd_addrb = 0;
        a_data = 0; b_data = 0;
        @(negedge clock);
        #1;
        checks++;
        if (enc !== 1'b0 || addrc !== 32'd0 || datac !== 32'd0 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: enc=%b addrc=%0d datac=%h init_done=%b, required 0 0 0 0",
                     enc, addrc, datac, init_done);
        end
        checks++;
        if (hazard_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_hazard_init: hazard_a=%b, required 1", hazard_a);
        end
    endtask

    task automatic test_sweep;
        @(negedge clock);
        reset = 1'b1;
        a_valid = 1; a_addr = 5'd2; a_data = 32'h1234;
        issue_valid = 1; issue_addr = 5'd12;
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            checks++;
            if (enc !== 1'b1 || addrc !== 32'(i) || datac !== 32'd0) begin
                errors++;
                $display("FAIL sweep_%0d: enc=%b addrc=%0d datac=%h, required 1 %0d 0",
                         i, enc, addrc, datac, i);
            end
            checks++;
            if (a_ready !== 1'b0 || init_done !== 1'b0) begin
                errors++;
                $display("FAIL sweep_ready_%0d: a_ready=%b init_done=%b, required 0 0",
                         i, a_ready, init_done);
            end
        end
        a_valid = 0; issue_valid = 0; rd_addra = 5'd12;
        @(negedge clock);
        checks++;
        if (init_done !== 1'b1 || enc !== 1'b0) begin
            errors++;
            $display("FAIL sweep_done: init_done=%b enc=%b, required 1 0", init_done, enc);
        end
        checks++;
        if (hazard_a !== 1'b0) begin
            errors++;
            $display("FAIL init_issue_ignored: hazard_a=%b, required 0", hazard_a);
        end
    endtask

    task automatic test_single_a;
        a_valid = 1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL a_only_ready: a_ready=%b b_ready=%b, required 1 0", a_ready, b_ready);
        end
        @(negedge clock);
        a_valid = 0;
        checks++;
        if (enc !== 1'b1 || addrc !== 32'd5 || datac !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL a_only_write: enc=%b addrc=%0d datac=%h, required 1 5 deadbeef",
                     enc, addrc, datac);
        end
        b_valid = 1; b_addr = 5'd6; b_data = 32'hB0B0_0006;
        #1;
        checks++;
        if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL b_only_ready: b_ready=%b a_ready=%b, required 1 0", b_ready, a_ready);
        end
        @(negedge clock);
        b_valid = 0;
        checks++;
        if (enc !== 1'b1 || addrc !== 32'd6 || datac !== 32'hB0B0_0006) begin
            errors++;
            $display("FAIL b_only_write: enc=%b addrc=%0d datac=%h, required 1 6 b0b00006",
                     enc, addrc, datac);
        end
        @(negedge clock);
        checks++;
        if (enc !== 1'b0) begin
            errors++;
            $display("FAIL idle_enc: enc=%b, required 0", enc);
        end
    endtask

    task automatic test_back_to_back;
        a_valid = 1; a_addr = 5'd3; a_data = 32'hAAAA_0003;
        b_valid = 1; b_addr = 5'd4; b_data = 32'hBBBB_0004;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL rr_grant_%0d: a_ready=%b b_ready=%b, required %0d %0d",
                         i, a_ready, b_ready, (i % 2 == 0), (i % 2 == 1));
            end
            @(negedge clock);
            checks++;
            if (enc !== 1'b1 || addrc !== ((i % 2 == 0) ? 32'd3 : 32'd4) ||
                datac !== ((i % 2 == 0) ? 32'hAAAA_0003 : 32'hBBBB_0004)) begin
                errors++;
                $display("FAIL rr_write_%0d: enc=%b addrc=%0d datac=%h", i, enc, addrc, datac);
            end
        end
        a_valid = 0; b_valid = 0;
        @(negedge clock);
        checks++;
        if (enc !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle: enc=%b, required 0", enc);
        end
    endtask

    task automatic test_hazard;
        logic exp_commit_haz;
`ifdef REGFILE_CTRL_BYPASS_EN
        exp_commit_haz = 1'b0;
`else
        exp_commit_haz = 1'b1;
`endif
        issue_valid = 1; issue_addr = 5'd7; rd_addra = 5'd7; rd_addrb = 5'd0;
        @(negedge clock);
        issue_valid = 0;
        checks++;
        if (hazard_a !== 1'b1 || hazard_b !== 1'b0) begin
            errors++;
            $display("FAIL haz_set: hazard_a=%b hazard_b=%b, required 1 0", hazard_a, hazard_b);
        end
        @(negedge clock);
        a_valid = 1; a_addr = 5'd7; a_data = 32'h77;
        #1;
        checks++;
        if (a_ready !== 1'b1 || hazard_a !== 1'b1) begin
            errors++;
            $display("FAIL haz_hold: a_ready=%b hazard_a=%b, required 1 1", a_ready, hazard_a);
        end
        @(negedge clock);
        a_valid = 0;
        checks++;
        if (enc !== 1'b1 || addrc !== 32'd7 || hazard_a !== exp_commit_haz) begin
            errors++;
            $display("FAIL haz_commit: enc=%b addrc=%0d hazard_a=%b, required 1 7 %b",
                     enc, addrc, hazard_a, exp_commit_haz);
        end
        @(negedge clock);
        checks++;
        if (hazard_a !== 1'b0) begin
            errors++;
            $display("FAIL haz_clear: hazard_a=%b, required 0", hazard_a);
        end
        // Issue of 8 lands on the same edge that commits 8: the bit must stay set.
        issue_valid = 1; issue_addr = 5'd8; rd_addra = 5'd8;
        @(negedge clock);
        issue_valid = 0;
        a_valid = 1; a_addr = 5'd8; a_data = 32'h88;
        @(negedge clock);
        a_valid = 0;
        issue_valid = 1; issue_addr = 5'd8;
        @(negedge clock);
        issue_valid = 0;
        checks++;
        if (hazard_a !== 1'b1 || enc !== 1'b0) begin
            errors++;
            $display("FAIL set_wins: hazard_a=%b enc=%b, required 1 0", hazard_a, enc);
        end
        a_valid = 1;
        @(negedge clock);
        a_valid = 0;
        @(negedge clock);
        checks++;
        if (hazard_a !== 1'b0) begin
            errors++;
            $display("FAIL set_wins_clear: hazard_a=%b, required 0", hazard_a);
        end
        // Register 0: accepted, never written, never pending.
        issue_valid = 1; issue_addr = 5'd0; rd_addra = 5'd0;
        a_valid = 1; a_addr = 5'd0; a_data = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (a_ready !== 1'b1 || hazard_a !== 1'b0) begin
            errors++;
            $display("FAIL r0_accept: a_ready=%b hazard_a=%b, required 1 0", a_ready, hazard_a);
        end
        @(negedge clock);
        a_valid = 0; issue_valid = 0;
        checks++;
        if (enc !== 1'b0 || hazard_a !== 1'b0) begin
            errors++;
            $display("FAIL r0_no_write: enc=%b hazard_a=%b, required 0 0", enc, hazard_a);
        end
    endtask

`ifdef REGFILE_CTRL_BYPASS_EN
    task automatic test_bypass;
        issue_valid = 1; issue_addr = 5'd9; rd_addra = 5'd0; rd_addrb = 5'd9;
        @(negedge clock);
        issue_valid = 0;
        a_valid = 1; a_addr = 5'd9; a_data = 32'h55;
        @(negedge clock);
        a_valid = 0;
        checks++;
        if (byp_b_valid !== 1'b1 || byp_b_data !== 32'h55 || hazard_b !== 1'b0 || byp_a_valid !== 1'b0) begin
            errors++;
            $display("FAIL bypass_hit: byp_b_valid=%b byp_b_data=%h hazard_b=%b byp_a_valid=%b, required 1 55 0 0",
                     byp_b_valid, byp_b_data, hazard_b, byp_a_valid);
        end
        @(negedge clock);
        checks++;
        if (byp_b_valid !== 1'b0 || hazard_b !== 1'b0) begin
            errors++;
            $display("FAIL bypass_after: byp_b_valid=%b hazard_b=%b, required 0 0", byp_b_valid, hazard_b);
        end
    endtask
`endif

    task automatic test_mid_sweep_reset;
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (11) @(negedge clock);
        checks++;
        if (enc !== 1'b1 || addrc !== 32'd10) begin
            errors++;
            $display("FAIL mid_sweep_pos: enc=%b addrc=%0d, required 1 10", enc, addrc);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (enc !== 1'b0 || addrc !== 32'd0 || datac !== 32'd0 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: enc=%b addrc=%0d datac=%h init_done=%b, required 0 0 0 0",
                     enc, addrc, datac, init_done);
        end
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            checks++;
            if (enc !== 1'b1 || addrc !== 32'(i)) begin
                errors++;
                $display("FAIL sweep_restart_%0d: enc=%b addrc=%0d, required 1 %0d", i, enc, addrc, i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_single_a();
        test_back_to_back();
        test_hazard();
`ifdef REGFILE_CTRL_BYPASS_EN
        test_bypass();
`endif
        test_mid_sweep_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
